bird_motion: RTL and testbench
==============================

# bird_motion

Upstream game-logic stage that computes the bird's vertical position and wing-animation sprite index each video frame and drives `bird_v_in` / `bird_state_input` of the display stage. Integrates gravity and flap impulses on an internally generated frame tick, synchronises and edge-detects the raw flap button, detects ground impact, and holds the bird at its start height outside of play.

## Interface
- `TICK_DIV`, 1666667: clocks per frame tick (100 MHz / 60 Hz).
- `GRAVITY`, 1: velocity increment per tick, pixels/tick.
- `FLAP_VEL`, 8: upward speed loaded on a flap, pixels/tick.
- `VMAX`, 10: maximum downward velocity.
- `Y_START`, 240: hold/reset height.
- `Y_MAX`, 464: ground height (bird top at ground contact).
- `ANIM_DIV`, 6: ticks per wing-animation step.
- `clk  in  1`  system clock.
- `rst_n  in  1`  asynchronous active-low reset.
- `flap  in  1`  raw button level, asynchronous to `clk`.
- `state  in  3`  game state: 0 MENU, 1 READY, 2 PLAY, 3 OVER; 4–7 treated as MENU.
- `bird_v  out  11`  bird top y, 0..Y_MAX.
- `bird_state  out  2`  sprite index: 0 up, 1 mid, 2 down, 3 crashed.
- `hit_ground  out  1`  level, high while in FALLEN.
- `frame_tick  out  1`  one-cycle pulse every TICK_DIV clocks.

## Operation
- Flap path: 2-FF synchroniser, rising-edge detect; edge sets `flap_pend`. Pending flap is consumed at the next tick; an edge in the same cycle as a tick is applied at that tick. Edges are ignored (pend cleared) unless FSM is FLY and `state`=PLAY.
- Velocity `vel`: signed 8-bit. Position math in signed 12-bit: `y_next = bird_v + vel_next`.
- Per tick in FLY: `vel_next = flap_pend ? -FLAP_VEL : min(vel+GRAVITY, VMAX)`.
  - `y_next < 0`: `bird_v`=0, `vel`=0.
  - `y_next >= Y_MAX`: `bird_v`=Y_MAX, `vel`=0, go FALLEN.
  - else `bird_v`=y_next, `vel`=vel_next.
- FSM:
  - HOLD: `bird_v`=Y_START, `vel`=0. Go FLY the clock `state`=PLAY.
  - FLY: physics as above. `state`=OVER: flaps ignored, gravity continues until ground. `state` MENU/READY: go HOLD.
  - FALLEN: `bird_v` frozen, `hit_ground`=1, `bird_state`=3. `state` MENU/READY: go HOLD.
- Animation: in HOLD/FLY, a counter steps `bird_state` 0→1→2→0 every ANIM_DIV ticks. In FLY with `state`=OVER, `bird_state` freezes at 2. Entering HOLD resets the counter and `bird_state` to 0.

## Timing
- Reset: `bird_v`=Y_START, `bird_state`=0, `hit_ground`=0, `frame_tick`=0, `vel`=0, tick and anim counters 0, `flap_pend`=0, FSM HOLD. Reset assertion takes effect immediately regardless of clock.
- `frame_tick` first asserts TICK_DIV clocks after reset deassertion, then every TICK_DIV clocks.
- `bird_v`, `bird_state`, and `hit_ground` update on the clock edge at which `frame_tick` is high, and are stable for the rest of the frame.
- Flap latency: 3 clocks (sync + edge) to `flap_pend`, then up to TICK_DIV clocks to the next tick.
- Multiple flap edges within one frame apply a single flap.
- HOLD→FLY transition is not tick-aligned. The first physics update occurs at the next tick.
- Ground and OVER in the same tick: go FALLEN.

## Configuration
- `BIRD_HOVER_EN` defined: in HOLD, `bird_v` bobs as a triangle wave Y_START-4..Y_START+4, 1 pixel per 4 ticks, starting upward from Y_START. HOLD→FLY starts from the current bobbed height.
- Not defined: in HOLD, `bird_v` is fixed at Y_START.

## Test plan
- Reset with `rst_n`=0 mid-frame, FSM in FLY at `bird_v`=300 → all outputs return to reset values within the same cycle.
- TICK_DIV=4, `state`=PLAY, no flap → `bird_v` 241, 243, 246, 250 on successive ticks; `vel` saturates at 10.
- Flap edge at `bird_v`=250 → next tick `bird_v`=242, then 235, 229. Two edges in the same frame → single flap.
- Repeated flaps from `bird_v`=5 → `bird_v` clamps at 0 with `vel`=0.
- Free-fall to ground → `bird_v`=464, `hit_ground`=1, `bird_state`=3. `state`=READY → HOLD, `bird_v`=240, `bird_state`=0.
- `state`=OVER while in FLY → flaps ignored, `bird_state` held at 2, bird reaches FALLEN. With `BIRD_HOVER_EN`, HOLD → `bird_v` cycles 240..244..236.

Source files
------------

// File: rtl/bird_motion.sv
// bird_motion: per-frame bird height, velocity, flap handling and wing animation.
// Optional BIRD_HOVER_EN: the bird bobs in a small triangle wave while held.
module bird_motion #(
  parameter int TICK_DIV = 1666667,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = 8,
  parameter int VMAX     = 10,
  parameter int Y_START  = 240,
  parameter int Y_MAX    = 464,
  parameter int ANIM_DIV = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flap,
  input  logic [2:0]  state,
  output logic [10:0] bird_v,
  output logic [1:0]  bird_state,
  output logic        hit_ground,
  output logic        frame_tick
);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int AW = $clog2(ANIM_DIV + 1);
  localparam logic signed [7:0]  GRAV = 8'(GRAVITY);
  localparam logic signed [7:0]  FV   = 8'(FLAP_VEL);
  localparam logic signed [7:0]  VMX  = 8'(VMAX);
  localparam logic signed [11:0] YMX  = 12'(Y_MAX);
  typedef enum logic [1:0] {HOLD, FLY, FALLEN} mode_t;
  mode_t                mode;
  logic [TW-1:0]        tick_cnt;
  logic [AW-1:0]        anim_cnt;
  logic [2:0]           sync;
  logic                 flap_pend;
  logic signed [7:0]    vel;
  logic [1:0]           st;
  logic                 play, over, rise, flap_go, anim_wrap, tick_wrap;
  logic signed [7:0]    vel_inc, vel_next;
  logic signed [11:0]   y_next;
  logic [1:0]           anim_next;
`ifdef BIRD_HOVER_EN
  logic [1:0]           hov_cnt;
  logic                 hov_dn;
`endif
  always_comb begin
    st        = state[2] ? 2'd0 : state[1:0];
    play      = st == 2'd2;
    over      = st == 2'd3;
    rise      = sync[1] & ~sync[2];
    flap_go   = (flap_pend | rise) & play;
    vel_inc   = vel + GRAV;
    vel_next  = flap_go ? -FV : (vel_inc > VMX ? VMX : vel_inc);
    y_next    = $signed({1'b0, bird_v}) + {{4{vel_next[7]}}, vel_next};
    anim_next = bird_state == 2'd2 ? 2'd0 : bird_state + 2'd1;
    anim_wrap = anim_cnt == AW'(ANIM_DIV - 1);
    tick_wrap = tick_cnt == TW'(TICK_DIV - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode       <= HOLD;
      tick_cnt   <= '0;
      anim_cnt   <= '0;
      sync       <= '0;
      flap_pend  <= 1'b0;
      vel        <= '0;
      bird_v     <= 11'(Y_START);
      bird_state <= 2'd0;
      hit_ground <= 1'b0;
      frame_tick <= 1'b0;
`ifdef BIRD_HOVER_EN
      hov_cnt    <= '0;
      hov_dn     <= 1'b0;
`endif
    end else begin
      sync       <= {sync[1:0], flap};
      frame_tick <= tick_wrap;
      tick_cnt   <= tick_wrap ? '0 : tick_cnt + TW'(1);
      // Leaving play from any active mode snaps straight back to the held pose.
      if (mode != HOLD && !play && !over) begin
        mode       <= HOLD;
        bird_v     <= 11'(Y_START);
        vel        <= '0;
        bird_state <= 2'd0;
        anim_cnt   <= '0;
        flap_pend  <= 1'b0;
        hit_ground <= 1'b0;
`ifdef BIRD_HOVER_EN
        hov_cnt    <= '0;
        hov_dn     <= 1'b0;
`endif
      end else
        case (mode)
          HOLD: begin
            flap_pend <= 1'b0;
            if (frame_tick) begin
              anim_cnt <= anim_wrap ? '0 : anim_cnt + AW'(1);
              if (anim_wrap) bird_state <= anim_next;
`ifdef BIRD_HOVER_EN
              hov_cnt <= hov_cnt + 2'd1;
              if (hov_cnt == 2'd3) begin
                bird_v <= hov_dn ? bird_v - 11'd1 : bird_v + 11'd1;
                if (!hov_dn && bird_v == 11'(Y_START + 3)) hov_dn <= 1'b1;
                if (hov_dn && bird_v == 11'(Y_START - 3)) hov_dn <= 1'b0;
              end
`endif
            end
            if (play) mode <= FLY;
          end
          FLY:
            if (frame_tick) begin
              flap_pend <= 1'b0;
              if (over) bird_state <= 2'd2;
              else begin
                anim_cnt <= anim_wrap ? '0 : anim_cnt + AW'(1);
                if (anim_wrap) bird_state <= anim_next;
              end
              if (y_next[11]) begin
                bird_v <= '0;
                vel    <= '0;
              end else if (y_next >= YMX) begin
                bird_v     <= 11'(Y_MAX);
                vel        <= '0;
                mode       <= FALLEN;
                hit_ground <= 1'b1;
                bird_state <= 2'd3;
              end else begin
                bird_v <= y_next[10:0];
                vel    <= vel_next;
              end
            end else
              flap_pend <= flap_go;
          FALLEN: flap_pend <= 1'b0;
          default: mode <= HOLD;
        endcase
    end
endmodule

// File: tb/tb_bird_motion.sv
// tb_bird_motion: random and directed stimulus against a per-cycle behavioural model.
module tb_bird_motion;
  localparam int TD = 16;
  logic        clk = 1'b0, rst_n = 1'b0, flap = 1'b0;
  logic [2:0]  state = 3'd0;
  logic [10:0] bird_v;
  logic [1:0]  bird_state;
  logic        hit_ground, frame_tick;
  int checks = 0, errors = 0;

  bird_motion #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .flap(flap), .state(state),
    .bird_v(bird_v), .bird_state(bird_state), .hit_ground(hit_ground), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: 0 held, 1 flying, 2 on the ground; flap history kept as sampled levels.
  int m_y, m_vel, m_bs, m_ac, m_mode, cyc;
  bit m_pend, m_tick, m_hit;
  bit fq[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_y = 240; m_vel = 0; m_bs = 0; m_ac = 0; m_mode = 0; cyc = 0;
      m_pend = 0; m_tick = 0; m_hit = 0; fq = '{0, 0, 0};
    end else begin
      int st, vn, yn;
      bit rise, tick, fl;
      st   = state > 3 ? 0 : int'(state);
      rise = fq[$-1] && !fq[$-2];
      fq.push_back(flap);
      if (fq.size() > 4) void'(fq.pop_front());
      tick = m_tick;
      cyc++;
      m_tick = (cyc % TD) == 0;
      if (m_mode != 0 && st < 2) begin
        m_mode = 0; m_y = 240; m_vel = 0; m_bs = 0; m_ac = 0; m_pend = 0; m_hit = 0;
      end else if (m_mode == 0) begin
        m_pend = 0;
        if (tick) begin
          m_ac++;
          if (m_ac == 6) begin m_ac = 0; m_bs = (m_bs + 1) % 3; end
        end
        if (st == 2) m_mode = 1;
      end else if (m_mode == 1) begin
        if (tick) begin
          fl = (m_pend || rise) && st == 2;
          m_pend = 0;
          vn = fl ? -8 : (m_vel + 1 > 10 ? 10 : m_vel + 1);
          if (st == 3) m_bs = 2;
          else begin
            m_ac++;
            if (m_ac == 6) begin m_ac = 0; m_bs = (m_bs + 1) % 3; end
          end
          yn = m_y + vn;
          if (yn < 0) begin m_y = 0; m_vel = 0; end
          else if (yn >= 464) begin m_y = 464; m_vel = 0; m_mode = 2; m_bs = 3; m_hit = 1; end
          else begin m_y = yn; m_vel = vn; end
        end else
          m_pend = (m_pend || rise) && st == 2;
      end else
        m_pend = 0;
    end
  end

  always @(negedge clk)
    if (rst_n) begin
      chk("bird_v", bird_v, m_y);
      chk("bird_state", bird_state, m_bs);
      chk("hit_ground", hit_ground, m_hit);
      chk("frame_tick", frame_tick, m_tick);
    end

  task automatic upd();
    int n = 0;
    while (frame_tick !== 1'b1 && n < 4 * TD) begin @(negedge clk); n++; end
    chk("tick_timeout", n < 4 * TD, 1);
    @(negedge clk);
  endtask

  task automatic pulse();
    flap = 1'b1; repeat (2) @(negedge clk);
    flap = 1'b0; repeat (2) @(negedge clk);
  endtask

  task automatic wait_ground();
    int n = 0;
    while (hit_ground !== 1'b1 && n < 100 * TD) begin @(negedge clk); n++; end
    chk("ground_timeout", n < 100 * TD, 1);
  endtask

  initial begin
    int n, y0;
    repeat (3) @(negedge clk);
    chk("rst_v", bird_v, 240);
    chk("rst_bs", bird_state, 0);
    chk("rst_hit", hit_ground, 0);
    chk("rst_tick", frame_tick, 0);
    rst_n = 1'b1; state = 3'd2;
    n = 0;
    do begin @(negedge clk); n++; end while (frame_tick !== 1'b1 && n < 100);
    chk("first_tick", n, TD);
    @(negedge clk);
    chk("fall1", bird_v, 241);
    upd(); chk("fall2", bird_v, 243);
    upd(); chk("fall3", bird_v, 246);
    upd(); chk("fall4", bird_v, 250);
    pulse(); pulse();
    upd(); chk("flap1", bird_v, 242);
    upd(); chk("flap2", bird_v, 235);
    upd(); chk("flap3", bird_v, 229);
    wait_ground();
    @(negedge clk);
    chk("gnd_v", bird_v, 464);
    chk("gnd_bs", bird_state, 3);
    chk("gnd_hit", hit_ground, 1);
    state = 3'd1;
    @(negedge clk);
    chk("hold_v", bird_v, 240);
    chk("hold_bs", bird_state, 0);
    chk("hold_hit", hit_ground, 0);
    state = 3'd2;
    repeat (40) begin pulse(); upd(); end
    chk("clamp_v", bird_v, 0);
    state = 3'd3;
    upd();
    chk("over_bs", bird_state, 2);
    y0 = int'(bird_v);
    pulse();
    upd();
    chk("over_noflap", int'(bird_v) > y0, 1);
    chk("over_bs2", bird_state, 2);
    wait_ground();
    @(negedge clk);
    chk("over_gnd_bs", bird_state, 3);
    chk("over_gnd_v", bird_v, 464);
    state = 3'd0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 99) < 2)
        state = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      if ($urandom_range(0, 5) == 0) flap = ~flap;
      @(negedge clk);
    end
    flap = 1'b0; state = 3'd1;
    repeat (3) @(negedge clk);
    state = 3'd2;
    upd(); upd(); upd();
    n = 0;
    while (frame_tick !== 1'b1 && n < 4 * TD) begin @(negedge clk); n++; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_v", bird_v, 240);
    chk("arst_bs", bird_state, 0);
    chk("arst_hit", hit_ground, 0);
    chk("arst_tick", frame_tick, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * TD) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
